// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit
//
// Multi-cycle fetch and next-PC stage. The unit owns the program counter, the
// instruction register and the carry flag. Each instruction passes through
// three phases: FETCH, WAIT_ISSUE and RESOLVE.
//   FETCH      : request imem at pc and capture the returned word on imem_ack.
//   WAIT_ISSUE : present instr to decode until dec_ready.
//   RESOLVE    : wait for res_valid, then load pc with the branch target or pc+4.
//
// Ports
//   clk, rst_n            core clock and asynchronous active-low reset
//   imem_req/imem_addr    fetch request and address (imem_addr = pc)
//   imem_ack/imem_rdata   fetch response
//   instr/instr_valid     instruction register and its handoff strobe to decode
//   dec_ready             decode accepts instr
//   res_valid             branch resolution inputs are valid this cycle
//   cond_jump/uncond_jump/addr_sel  control-unit branch controls
//   rs_val                value of register rs
//   flag_we/carry_in      carry flag update strobe and value
//   pc/link_addr          current pc and pc+4 (link address for bl)
//   carry_flag            registered carry flag
module fetch_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        res_valid,
  input  logic [2:0]  cond_jump,
  input  logic        uncond_jump,
  input  logic [1:0]  addr_sel,
  input  logic [31:0] rs_val,
  input  logic        flag_we,
  input  logic        carry_in,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        carry_flag
);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    WAIT_ISSUE = 2'd1,
    RESOLVE    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        carry_q;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        taken;
  logic [31:0] pc_nxt;

  function automatic logic cond_eval(
    input logic [2:0]  cj,
    input logic [31:0] rs,
    input logic        cf
  );
    logic c;
    case (cj)
      3'b001:  c = rs[31];
      3'b010:  c = (rs == 32'd0);
      3'b011:  c = (rs != 32'd0);
      3'b100:  c = cf;
      3'b101:  c = ~cf;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] target_calc(
    input logic [1:0]  sel,
    input logic [31:0] pc4,
    input logic [31:0] ir,
    input logic [31:0] rs
  );
    logic signed [31:0] off26;
    logic signed [31:0] off16;
    logic [31:0]        t;
    off26 = {{4{ir[25]}}, ir[25:0], 2'b00};
    off16 = {{14{ir[15]}}, ir[15:0], 2'b00};
    case (sel)
      2'b00:   t = pc4 + off26;
      2'b01:   t = {rs[31:2], 2'b00};
      2'b10:   t = pc4 + off16;
      default: t = pc4;  // reserved encoding always falls through
    endcase
    return t;
  endfunction

  assign pc_plus4 = pc_q + 32'd4;
  assign taken    = uncond_jump | cond_eval(cond_jump, rs_val, carry_q);
  assign target   = target_calc(addr_sel, pc_plus4, instr_q, rs_val);
  assign pc_nxt   = taken ? target : pc_plus4;

  // ---- control: phase sequencing ----
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = WAIT_ISSUE;
      end
      WAIT_ISSUE: begin
        instr_valid = 1'b1;
        if (dec_ready) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (res_valid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // ---- architectural state: pc, instr, carry ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      carry_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) instr_q <= imem_rdata;
      if (state == RESOLVE && res_valid) pc_q <= pc_nxt;
      // Resolution above already sampled the pre-edge carry_q.
      if (flag_we) carry_q <= carry_in;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign carry_flag = carry_q;
  assign link_addr  = pc_plus4;

endmodule

// File: tb/tb_fetch_branch_unit.sv
module tb_fetch_branch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        dec_ready;
  logic        res_valid;
  logic [2:0]  cond_jump;
  logic        uncond_jump;
  logic [1:0]  addr_sel;
  logic [31:0] rs_val;
  logic        flag_we;
  logic        carry_in;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        carry_flag;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_pc;
  logic        exp_cf;

  fetch_branch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .dec_ready(dec_ready),
    .res_valid(res_valid), .cond_jump(cond_jump), .uncond_jump(uncond_jump),
    .addr_sel(addr_sel), .rs_val(rs_val),
    .flag_we(flag_we), .carry_in(carry_in),
    .pc(pc), .link_addr(link_addr), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Next pc computed directly from the branch rules.
  function automatic logic [31:0] ref_next(
    input logic [31:0] cur, input logic [31:0] w, input logic [2:0] cj,
    input logic uj, input logic [1:0] as, input logic [31:0] rs, input logic cf);
    logic t;
    logic signed [31:0] o26, o16;
    logic [31:0] seq;
    seq = cur + 32'd4;
    case (cj)
      3'd1:    t = rs[31];
      3'd2:    t = (rs == 32'd0);
      3'd3:    t = (rs != 32'd0);
      3'd4:    t = cf;
      3'd5:    t = !cf;
      default: t = 1'b0;
    endcase
    t = t | uj;
    o26 = 32'($signed(w[25:0]));
    o16 = 32'($signed(w[15:0]));
    if (!t || as == 2'b11) return seq;
    if (as == 2'b00) return seq + 32'(o26 * 32'sd4);
    if (as == 2'b01) return rs & 32'hFFFF_FFFC;
    return seq + 32'(o16 * 32'sd4);
  endfunction

  // Called just after a falling edge with the DUT in FETCH.
  task automatic run_instr(input string tag, input logic [31:0] w, input logic [2:0] cj,
                           input logic uj, input logic [1:0] as, input logic [31:0] rs,
                           input int ad, input int dd, input int rd,
                           input logic fw, input logic ci);
    logic [31:0] nxt;
    logic fs, cs;
    for (int i = 0; i < ad; i++) begin
      imem_ack = 1'b0; res_valid = 1'b1; dec_ready = 1'b1; imem_rdata = $urandom;
      chk({tag, "/req_stall"}, 32'(imem_req), 32'd1);
      chk({tag, "/addr_stall"}, imem_addr, exp_pc);
      @(negedge clk);
    end
    chk({tag, "/req"}, 32'(imem_req), 32'd1);
    chk({tag, "/addr"}, imem_addr, exp_pc);
    imem_ack = 1'b1; imem_rdata = w; res_valid = 1'b1; dec_ready = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0; res_valid = 1'b0; imem_rdata = $urandom;
    chk({tag, "/ivalid"}, 32'(instr_valid), 32'd1);
    chk({tag, "/instr"}, instr, w);
    chk({tag, "/req_drop"}, 32'(imem_req), 32'd0);
    chk({tag, "/link_wi"}, link_addr, exp_pc + 32'd4);
    for (int i = 0; i < dd; i++) begin
      fs = 1'($urandom); cs = 1'($urandom);
      dec_ready = 1'b0; imem_ack = 1'b1; res_valid = 1'b1; flag_we = fs; carry_in = cs;
      @(negedge clk);
      flag_we = 1'b0;
      if (fs) exp_cf = cs;
      chk({tag, "/ivalid_stall"}, 32'(instr_valid), 32'd1);
      chk({tag, "/instr_stall"}, instr, w);
      chk({tag, "/cf_wi"}, 32'(carry_flag), 32'(exp_cf));
    end
    dec_ready = 1'b1; imem_ack = 1'b1; res_valid = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0; imem_ack = 1'b0; res_valid = 1'b0;
    chk({tag, "/ivalid_res"}, 32'(instr_valid), 32'd0);
    chk({tag, "/req_res"}, 32'(imem_req), 32'd0);
    chk({tag, "/link_res"}, link_addr, exp_pc + 32'd4);
    for (int i = 0; i < rd; i++) begin
      fs = 1'($urandom); cs = 1'($urandom);
      res_valid = 1'b0; imem_ack = 1'b1; dec_ready = 1'b1; flag_we = fs; carry_in = cs;
      cond_jump = 3'($urandom); uncond_jump = 1'($urandom);
      addr_sel = 2'($urandom); rs_val = $urandom;
      @(negedge clk);
      flag_we = 1'b0;
      if (fs) exp_cf = cs;
      chk({tag, "/pc_stall"}, pc, exp_pc);
      chk({tag, "/req_rstall"}, 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0; dec_ready = 1'b0; res_valid = 1'b1;
    cond_jump = cj; uncond_jump = uj; addr_sel = as; rs_val = rs;
    flag_we = fw; carry_in = ci;
    nxt = ref_next(exp_pc, w, cj, uj, as, rs, exp_cf);
    @(negedge clk);
    res_valid = 1'b0; flag_we = 1'b0;
    exp_pc = nxt;
    if (fw) exp_cf = ci;
    chk({tag, "/pc"}, pc, exp_pc);
    chk({tag, "/addr_next"}, imem_addr, exp_pc);
    chk({tag, "/req_next"}, 32'(imem_req), 32'd1);
    chk({tag, "/cf"}, 32'(carry_flag), 32'(exp_cf));
  endtask

  task automatic flag_cycle(input logic ci);
    imem_ack = 1'b0; flag_we = 1'b1; carry_in = ci;
    @(negedge clk);
    flag_we = 1'b0;
    exp_cf = ci;
    chk("flag_fetch/cf", 32'(carry_flag), 32'(ci));
    chk("flag_fetch/addr", imem_addr, exp_pc);
  endtask

  initial begin
    logic [31:0] w, rs;
    logic [2:0]  cj;
    logic        uj;
    logic [1:0]  as;

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; dec_ready = 1'b0;
    res_valid = 1'b0; cond_jump = 3'd0; uncond_jump = 1'b0; addr_sel = 2'd0;
    rs_val = 32'd0; flag_we = 1'b0; carry_in = 1'b0;
    exp_pc = RST_PC; exp_cf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/pc", pc, RST_PC);
    chk("rst/instr", instr, 32'd0);
    chk("rst/ivalid", 32'(instr_valid), 32'd0);
    chk("rst/cf", 32'(carry_flag), 32'd0);
    rst_n = 1'b1;
    chk("rst/req", 32'(imem_req), 32'd1);
    chk("rst/addr", imem_addr, RST_PC);

    // sequential with 5-cycle ack stall
    run_instr("seq", $urandom, 3'd0, 1'b0, 2'd0, $urandom, 5, 0, 0, 1'b0, 1'b0);
    chk("seq/const", pc, 32'h104);
    // br
    run_instr("br", $urandom, 3'd0, 1'b1, 2'd1, 32'h2003, 0, 0, 0, 1'b0, 1'b0);
    chk("br/const", pc, 32'h2000);
    run_instr("br100", $urandom, 3'd0, 1'b1, 2'd1, 32'h100, 0, 1, 1, 1'b0, 1'b0);
    // b -2 words
    w = {6'($urandom), 26'h3FF_FFFE};
    run_instr("b", w, 3'd0, 1'b1, 2'd0, $urandom, 0, 0, 0, 1'b0, 1'b0);
    chk("b/const", pc, 32'h0FC);
    // conditional branches from 0x40, imm16 = 4
    w = {16'($urandom), 16'h0004};
    run_instr("br40a", $urandom, 3'd0, 1'b1, 2'd1, 32'h40, 0, 0, 0, 1'b0, 1'b0);
    run_instr("bz_t", w, 3'd2, 1'b0, 2'd2, 32'd0, 0, 0, 0, 1'b0, 1'b0);
    chk("bz_t/const", pc, 32'h54);
    run_instr("br40b", $urandom, 3'd0, 1'b1, 2'd1, 32'h40, 0, 0, 0, 1'b0, 1'b0);
    run_instr("bz_nt", w, 3'd2, 1'b0, 2'd2, 32'd5, 1, 2, 0, 1'b0, 1'b0);
    chk("bz_nt/const", pc, 32'h44);
    run_instr("br40c", $urandom, 3'd0, 1'b1, 2'd1, 32'h40, 0, 0, 0, 1'b0, 1'b0);
    run_instr("bltz", w, 3'd1, 1'b0, 2'd2, 32'h8000_0000, 0, 0, 0, 1'b0, 1'b0);
    chk("bltz/const", pc, 32'h54);
    run_instr("br40d", $urandom, 3'd0, 1'b1, 2'd1, 32'h40, 0, 0, 0, 1'b0, 1'b0);
    run_instr("bnz", w, 3'd3, 1'b0, 2'd2, 32'd0, 0, 0, 2, 1'b0, 1'b0);
    chk("bnz/const", pc, 32'h44);
    // carry flag
    flag_cycle(1'b1);
    run_instr("bcy", w, 3'd4, 1'b0, 2'd2, $urandom, 0, 0, 0, 1'b0, 1'b0);
    chk("bcy/const", pc, 32'h58);
    run_instr("bncy", w, 3'd5, 1'b0, 2'd2, $urandom, 0, 0, 0, 1'b0, 1'b0);
    chk("bncy/const", pc, 32'h5C);
    run_instr("bcy_we", w, 3'd4, 1'b0, 2'd2, $urandom, 0, 0, 0, 1'b1, 1'b0);
    chk("bcy_we/const", pc, 32'h70);
    chk("bcy_we/cf0", 32'(carry_flag), 32'd0);
    // wrap and reserved
    run_instr("brtop", $urandom, 3'd0, 1'b1, 2'd1, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1'b0);
    run_instr("wrap", $urandom, 3'd0, 1'b0, 2'd0, $urandom, 0, 0, 0, 1'b0, 1'b0);
    chk("wrap/const", pc, 32'h0);
    run_instr("rsvd", $urandom, 3'd1, 1'b1, 2'd3, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1'b0);
    chk("rsvd/const", pc, 32'h4);

    // random instructions
    for (int k = 0; k < 40; k++) begin
      w  = $urandom;
      cj = 3'($urandom_range(0, 7));
      uj = ($urandom_range(0, 3) == 0);
      as = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rs = 32'd0;
        1:       rs = 32'h8000_0000 | $urandom;
        default: rs = $urandom;
      endcase
      run_instr("rand", w, cj, uj, as, rs,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom));
    end

    // asynchronous reset in the middle of RESOLVE
    flag_cycle(1'b1);
    imem_ack = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 1'b0; dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    chk("midrst/in_resolve", 32'(instr_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst/pc", pc, RST_PC);
    chk("midrst/instr", instr, 32'd0);
    chk("midrst/ivalid", 32'(instr_valid), 32'd0);
    chk("midrst/cf", 32'(carry_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RST_PC; exp_cf = 1'b0;
    chk("midrst/req", 32'(imem_req), 32'd1);
    chk("midrst/addr", imem_addr, RST_PC);
    run_instr("postrst", $urandom, 3'd0, 1'b0, 2'd0, $urandom, 1, 0, 0, 1'b0, 1'b0);
    chk("postrst/const", pc, RST_PC + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_branch_unit.md
# fetch_branch_unit

Multi-cycle instruction fetch and next-PC stage of the KGPminiRISC core. It owns the program counter and instruction register, fetches from instruction memory over a req/ack handshake, and hands the instruction to decode. It then resolves the control-unit branch outputs (CondJump, UncondJump, AddrSel) together with the operand and carry flag to select the next PC. It also supplies the link address for `bl`.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst_n  input  1  **asynchronous, active-low reset.**
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc.
- imem_ack  input  1  instruction memory returns imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  instruction register.
- instr_valid  output  1  instr is presented to decode.
- dec_ready  input  1  decode accepts instr.
- res_valid  input  1  execute presents resolution inputs for the current instruction.
- cond_jump  input  3  CondJump from the control unit.
- uncond_jump  input  1  UncondJump from the control unit.
- addr_sel  input  2  AddrSel from the control unit.
- rs_val  input  32  value of register rs.
- flag_we  input  1  ALU carry update strobe.
- carry_in  input  1  ALU carry-out.
- pc  output  32  address of the current instruction.
- link_addr  output  32  pc + 4, written to ra by `bl`.
- carry_flag  output  1  registered carry flag.

## Operation
- FSM states: FETCH, WAIT_ISSUE, RESOLVE.
  - **FETCH:** imem_req=1, imem_addr=pc. On imem_ack, instr <= imem_rdata and the FSM goes to WAIT_ISSUE.
  - **WAIT_ISSUE:** instr_valid=1, held until dec_ready. On dec_ready the FSM goes to RESOLVE.
  - **RESOLVE:** waits for res_valid. On res_valid, pc <= taken ? target : pc+4, and the FSM returns to FETCH.
- Every instruction passes through RESOLVE. Non-branch instructions arrive with cond_jump=000 and uncond_jump=0, so they fall through to pc+4.
- taken = uncond_jump | cond, where cond is:
  - 001: rs_val[31]
  - 010: rs_val==0
  - 011: rs_val!=0
  - 100: carry_flag
  - 101: !carry_flag
  - 000, 110, 111: 0
- Target by addr_sel:
  - 00: pc+4 + (sext(instr[25:0])<<2)
  - 01: {rs_val[31:2],2'b00}
  - 10: pc+4 + (sext(instr[15:0])<<2)
  - 11: reserved; target = pc+4 regardless of taken.
- Arithmetic is 32-bit modulo 2^32. Wrap-around past 32'hFFFF_FFFC is silent.
- carry_flag <= carry_in whenever flag_we=1, in any state.
- Branch conditions use carry_flag as registered before the edge. A flag_we in the same cycle as res_valid does not affect that resolution.
- link_addr = pc+4 combinationally. It is valid throughout WAIT_ISSUE and RESOLVE.
- Ignored inputs:
  - imem_ack outside FETCH.
  - dec_ready outside WAIT_ISSUE.
  - res_valid outside RESOLVE.

## Timing
- Reset values (async assert, any state, including mid-fetch or mid-resolve):
  - pc = RESET_PC
  - instr = 0
  - carry_flag = 0
  - state = FETCH
  - imem_req = 1 combinationally once rst_n deasserts
  - instr_valid = 0
- Reset deassertion is synchronized externally. The first request is presented in the first cycle with rst_n=1.
- imem_req and imem_addr are Moore outputs of FETCH. They stay stable until imem_ack and drop in the cycle after the ack edge.
- Minimum latency per instruction is 3 cycles: ack in the first FETCH cycle, then dec_ready and res_valid each on their first cycle.
- A stalled ack, dec_ready or res_valid extends the corresponding state indefinitely. pc and instr stay unchanged.
- The new pc is visible on imem_addr in the cycle after the res_valid edge.

## Test plan
- Reset: drive rst_n=0 mid-RESOLVE, release -> pc=imem_addr=RESET_PC, imem_req=1, instr_valid=0, carry_flag=0.
- Sequential: pc=0x100; drive ack, dec_ready, res_valid with cond=000, uncond=0 -> next imem_addr=0x104, link_addr was 0x104; stall ack 5 cycles -> imem_req held, pc unchanged.
- `b` (uncond=1, addr_sel=00), pc=0x100, instr[25:0]=0x3FFFFFE (-2) -> pc=0x0FC. `br` with rs_val=0x2003 -> pc=0x2000.
- bz/bnz/bltz at pc=0x40, imm16=0x0004:
  - bz with rs_val=0 -> pc=0x54.
  - bz with rs_val=5 -> pc=0x44.
  - bltz with rs_val=0x80000000 -> pc=0x54.
  - bnz with rs_val=0 -> pc=0x44.
- Carry: flag_we=1, carry_in=1 in FETCH -> carry_flag=1; bcy taken, bncy not taken. flag_we=1, carry_in=0 in the same cycle as res_valid of bcy -> still taken, carry_flag=0 afterwards.
- Wrap and reserved cases:
  - pc=0xFFFF_FFFC, sequential -> pc=0x0000_0000.
  - addr_sel=11 with uncond=1 -> pc=pc+4.
  - res_valid pulsed during FETCH -> ignored.
